tanh_sigmoid_unit: RTL
======================

Name: tanh_sigmoid_unit

Overview:
- Parametrised, handshaked activation unit: computes tanh or sigmoid of a two's-complement fixed-point input.
- Method: odd-symmetry folding, saturation detection, two-entry LUT fetch from an external synchronous table, and linear interpolation between the entries.
- Successor to the single-width tanh/functionG path. Adds valid/ready flow control, a sigmoid mode, configurable widths and interpolation.
- Sits between the neuron accumulator output and the activation write-back.

Parameters:
- IN_W, 20, input width, two's complement.
- ADDR_W, 12, LUT address width (2^ADDR_W entries of non-negative tanh values).
- FRAC_W, 5, interpolation fraction bits taken from magnitude[FRAC_W-1:0].
- OUT_W, 16, output and LUT data width (Q1.(OUT_W-1)).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input operand valid.
- in_ready  out  1  unit can accept an operand.
- in_data  in  IN_W  operand, two's complement.
- in_func  in  1  0 = tanh, 1 = sigmoid; sampled with in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_W  result; tanh is signed, sigmoid is unsigned (MSB always 0).
- out_sat  out  1  result came from the saturation path.
- lut_rd_en  out  1  LUT read strobe.
- lut_addr  out  ADDR_W  LUT read address.
- lut_data  in  OUT_W  LUT data, valid the cycle after lut_rd_en (latency 1).

Behaviour:
- Reset values: in_ready=0 during reset, 1 the cycle after; out_valid=0; out_data=0; out_sat=0; lut_rd_en=0; lut_addr=0; FSM=IDLE.
- Accept occurs when in_valid && in_ready. in_ready=1 only in IDLE, so at most one operation is in flight.
- Operand folding on accept, with L = ADDR_W+FRAC_W:
  - sign = in_data[IN_W-1].
  - mag = |in_data| held in IN_W bits; -2^(IN_W-1) is representable and saturates.
  - Sigmoid mode: mag = mag>>1.
  - sat = |mag[IN_W-1:L].
  - addr = mag[L-1:FRAC_W]; frac = mag[FRAC_W-1:0].
- FSM states: IDLE, ADDR0, ADDR1, CAP1, CALC, DONE.
  - IDLE, on accept: if sat, load the saturation result and go to DONE (out_valid at T+1). Otherwise go to ADDR0.
  - ADDR0: lut_rd_en=1, lut_addr=addr. Go to ADDR1.
  - ADDR1: capture y0=lut_data. If addr==all-ones, lut_rd_en=0 and y1:=y0. Otherwise lut_rd_en=1, lut_addr=addr+1. Go to CAP1.
  - CAP1: capture y1 (unless already forced to y0). Go to CALC.
  - CALC: compute and register out_data, out_sat=0. Go to DONE.
  - DONE: out_valid=1. Go to IDLE on out_ready; otherwise hold out_data and out_sat stable.
- Latency, with accept at edge T: out_valid high from cycle T+5 on the interpolated path, T+1 on the saturated path.
- Interpolation:
  - diff = y1-y0, signed OUT_W+1 bits; prod = diff*frac, signed.
  - r = y0 + (prod>>>FRAC_W).
  - r is clamped to [0, 2^(OUT_W-1)-1] before sign handling.
- Sign and mode:
  - tanh: out = sign ? -r : r.
  - sigmoid: t = sign ? -r : r; out = (t + 2^(OUT_W-1))>>1, range 0..2^(OUT_W-1)-1.
- Saturation values:
  - tanh: +32767 when positive, -32768 (0x8000) when negative.
  - sigmoid: 32767 when positive, 0 when negative.
  - out_sat=1 in both modes.
- Simultaneous out_ready and in_valid in DONE: no same-cycle accept. The next accept happens in the IDLE cycle that follows.
- Reset mid-operation: the in-flight op is dropped, no result is emitted, and lut_rd_en drops in the same cycle reset is sampled.

Optional Feature:
- Macro: TANH_INTERP_ROUND_EN.
- Defined: r = y0 + ((prod + 2^(FRAC_W-1))>>>FRAC_W), i.e. round half up.
- Undefined: truncating arithmetic shift, as in Behaviour.
- Latency and interface are identical in both cases.

Decomposition:
- Package tanh_pkg holds:
  - the FSM state enum;
  - localparams for the tanh saturation values (+32767/-32768) and the sigmoid saturation values (32767/0);
  - the func encoding (FUNC_TANH=0, FUNC_SIGMOID=1).
- One sub-module, lut_interp_core: combinational y0/y1/frac/sign/func to result, holding the clamp, rounding macro and mode mapping. The FSM, folding and handshake stay in the top level.

Test Plan:
- Bench LUT model y[i]=8*i with defaults, tanh mode.
  - in_data=80 (addr 2, frac 16) -> out_data=20 at T+5; lut_addr 2 then 3; out_sat=0.
  - in_data=-80 -> out_data=0xFFEC.
- Saturation: in_data=0x20000 -> 32767, out_sat=1 at T+1, no lut_rd_en. in_data=0x80000 -> 0x8000. Sigmoid with in_data=0x80000 -> 0.
- Top entry: in_data=0x1FFFF -> one LUT read only (addr 4095), out_data=32760.
- Sigmoid: in_func=1, in_data=160 -> folded magnitude 80 -> out_data=16394. in_data=-160 -> 16374.
- Rounding, in_data=66 (addr 2, frac 2): out_data=16 without TANH_INTERP_ROUND_EN, 17 with it.
- Flow control and reset:
  - Hold out_ready=0 for 3 cycles in DONE -> out_data stable, in_ready=0.
  - Assert reset during ADDR1 -> next cycle out_valid=0, lut_rd_en=0, in_ready=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/tanh_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tanh_pkg
//  Description : Shared definitions for the tanh/sigmoid activation unit.
//                Holds the controller state encoding, the function select
//                encoding and the reference saturation codes for a 16-bit
//                Q1.15 result.
//  Revision    : 1.0  initial release
// ============================================================================
package tanh_pkg;

    // Controller states, explicitly encoded in three bits.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR0 = 3'd1,
        ST_ADDR1 = 3'd2,
        ST_CAP1  = 3'd3,
        ST_CALC  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Function select carried alongside the operand.
    localparam logic FUNC_TANH    = 1'b0;
    localparam logic FUNC_SIGMOID = 1'b1;

    // Saturation codes for the 16-bit result format.
    localparam int          SAT_REF_W    = 16;
    localparam logic [15:0] TANH_SAT_POS = 16'h7FFF;   // +32767
    localparam logic [15:0] TANH_SAT_NEG = 16'h8000;   // -32768
    localparam logic [15:0] SIG_SAT_POS  = 16'h7FFF;   // 32767
    localparam logic [15:0] SIG_SAT_NEG  = 16'h0000;   // 0

endpackage : tanh_pkg
`default_nettype wire

// File: rtl/lut_interp_core.sv
`default_nettype none
// ============================================================================
//  Module      : lut_interp_core
//  Description : Combinational interpolation between two adjacent LUT
//                entries, magnitude clamp and tanh/sigmoid output mapping.
//  Ports       : i_y0, i_y1  - LUT entries at addr and addr+1 (unsigned)
//                i_frac      - interpolation fraction
//                i_sign      - sign of the original operand
//                i_func      - 0 = tanh, 1 = sigmoid
//                o_result    - final activation value
//  Config      : TANH_INTERP_ROUND_EN - when defined, the interpolation step
//                is rounded half up instead of truncated.
//  Revision    : 1.0  initial release
// ============================================================================
module lut_interp_core
    import tanh_pkg::*;
#(
    parameter int FRAC_W = 5,
    parameter int OUT_W  = 16
) (
    input  logic [OUT_W-1:0]  i_y0,
    input  logic [OUT_W-1:0]  i_y1,
    input  logic [FRAC_W-1:0] i_frac,
    input  logic              i_sign,
    input  logic              i_func,
    output logic [OUT_W-1:0]  o_result
);

    // Product width: (OUT_W+1)-bit signed diff times (FRAC_W+1)-bit signed
    // fraction, plus one guard bit so the rounding offset cannot overflow.
    localparam int c_prod_w  = OUT_W + FRAC_W + 2;
    localparam int c_sum_w   = c_prod_w + 1;
    localparam int c_mag_max = (2 ** (OUT_W - 1)) - 1;

    logic signed [OUT_W:0]      w_diff;
    logic signed [FRAC_W:0]     w_frac_s;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [c_prod_w-1:0] w_prod_adj;
    logic signed [c_prod_w-1:0] w_step;
    logic signed [c_sum_w-1:0]  w_sum;
    logic        [OUT_W-1:0]    w_mag;
    logic        [OUT_W-1:0]    w_t;
    logic        [OUT_W:0]      w_sig_sum;

    always_comb begin
        w_diff   = $signed({1'b0, i_y1}) - $signed({1'b0, i_y0});
        w_frac_s = $signed({1'b0, i_frac});
        w_prod   = c_prod_w'(w_diff) * c_prod_w'(w_frac_s);
`ifdef TANH_INTERP_ROUND_EN
        w_prod_adj = w_prod + c_prod_w'(2 ** (FRAC_W - 1));
`else
        w_prod_adj = w_prod;
`endif
        w_step = w_prod_adj >>> FRAC_W;
        w_sum  = c_sum_w'($signed({1'b0, i_y0})) + c_sum_w'(w_step);

        // Clamp the magnitude into [0, 2^(OUT_W-1)-1] so negation is safe.
        if (w_sum[c_sum_w-1]) begin
            w_mag = '0;
        end else if (w_sum > c_sum_w'(c_mag_max)) begin
            w_mag = OUT_W'(c_mag_max);
        end else begin
            w_mag = w_sum[OUT_W-1:0];
        end

        w_t = i_sign ? (OUT_W'(0) - w_mag) : w_mag;

        // Sigmoid: (t + 2^(OUT_W-1)) >> 1 with t sign-extended by one bit;
        // the carry out of OUT_W+1 bits is discarded by design.
        w_sig_sum = {w_t[OUT_W-1], w_t} + {2'b01, {(OUT_W-1){1'b0}}};

        o_result = (i_func == FUNC_SIGMOID) ? OUT_W'(w_sig_sum >> 1) : w_t;
    end

endmodule : lut_interp_core
`default_nettype wire

// File: rtl/tanh_sigmoid_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tanh_sigmoid_unit
//  Description : Handshaked tanh / sigmoid activation. Folds the operand to
//                a magnitude, detects saturation, fetches two adjacent
//                entries from an external synchronous LUT (latency 1) and
//                interpolates between them. One operation in flight.
//  Ports       : clock, reset           - clock, synchronous active-high reset
//                in_valid/in_ready      - operand handshake
//                in_data, in_func       - operand and function select
//                out_valid/out_ready    - result handshake
//                out_data, out_sat      - result and saturation flag
//                lut_rd_en, lut_addr    - LUT read request
//                lut_data               - LUT read data (cycle after request)
//  Config      : TANH_INTERP_ROUND_EN - round-half-up interpolation step
//                (applied in lut_interp_core).
//  Revision    : 1.0  initial release
// ============================================================================
module tanh_sigmoid_unit
    import tanh_pkg::*;
#(
    parameter int IN_W   = 20,
    parameter int ADDR_W = 12,
    parameter int FRAC_W = 5,
    parameter int OUT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_func,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat,
    output logic              lut_rd_en,
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [OUT_W-1:0]  lut_data
);

    localparam int c_idx_w = ADDR_W + FRAC_W;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                sign_q, sign_d;
    logic                func_q, func_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [FRAC_W-1:0]   frac_q, frac_d;
    logic [OUT_W-1:0]    y0_q, y0_d;
    logic [OUT_W-1:0]    y1_q, y1_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic                out_sat_q, out_sat_d;

    logic [IN_W-1:0]     w_abs;
    logic [IN_W-1:0]     w_mag;
    logic                w_sat;
    logic [ADDR_W-1:0]   w_addr;
    logic [FRAC_W-1:0]   w_frac;
    logic                w_accept;
    logic                w_addr_last;
    logic [OUT_W-1:0]    w_interp;
    logic [OUT_W-1:0]    w_sat_val;
    logic [OUT_W-1:0]    w_tanh_sat_pos;
    logic [OUT_W-1:0]    w_tanh_sat_neg;
    logic [OUT_W-1:0]    w_sig_sat_pos;
    logic [OUT_W-1:0]    w_sig_sat_neg;

    // ------------------------------------------------------------------
    // Operand folding. The most negative input negates to itself, which
    // reads as 2^(IN_W-1) unsigned and therefore lands on the sat path.
    // ------------------------------------------------------------------
    always_comb begin
        w_abs = in_data[IN_W-1] ? (IN_W'(0) - in_data) : in_data;
        w_mag = (in_func == FUNC_SIGMOID) ? (w_abs >> 1) : w_abs;
    end

    generate
        if (IN_W > c_idx_w) begin : g_sat_det
            assign w_sat = |w_mag[IN_W-1:c_idx_w];
        end else begin : g_sat_none
            assign w_sat = 1'b0;
        end
    endgenerate

    assign w_addr      = w_mag[c_idx_w-1:FRAC_W];
    assign w_frac      = w_mag[FRAC_W-1:0];
    assign w_accept    = in_valid && in_ready;
    assign w_addr_last = &addr_q;

    // Saturation codes: package values at the reference width, otherwise
    // full-scale codes derived from OUT_W.
    generate
        if (OUT_W == SAT_REF_W) begin : g_sat_pkg
            assign w_tanh_sat_pos = TANH_SAT_POS;
            assign w_tanh_sat_neg = TANH_SAT_NEG;
            assign w_sig_sat_pos  = SIG_SAT_POS;
            assign w_sig_sat_neg  = SIG_SAT_NEG;
        end else begin : g_sat_gen
            assign w_tanh_sat_pos = {1'b0, {(OUT_W-1){1'b1}}};
            assign w_tanh_sat_neg = {1'b1, {(OUT_W-1){1'b0}}};
            assign w_sig_sat_pos  = {1'b0, {(OUT_W-1){1'b1}}};
            assign w_sig_sat_neg  = '0;
        end
    endgenerate

    always_comb begin
        if (in_func == FUNC_SIGMOID) begin
            w_sat_val = in_data[IN_W-1] ? w_sig_sat_neg : w_sig_sat_pos;
        end else begin
            w_sat_val = in_data[IN_W-1] ? w_tanh_sat_neg : w_tanh_sat_pos;
        end
    end

    lut_interp_core #(
        .FRAC_W (FRAC_W),
        .OUT_W  (OUT_W)
    ) u_core (
        .i_y0     (y0_q),
        .i_y1     (y1_q),
        .i_frac   (frac_q),
        .i_sign   (sign_q),
        .i_func   (func_q),
        .o_result (w_interp)
    );

    // ------------------------------------------------------------------
    // State and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            sign_q     <= 1'b0;
            func_q     <= FUNC_TANH;
            addr_q     <= '0;
            frac_q     <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            sign_q     <= sign_d;
            func_q     <= func_d;
            addr_q     <= addr_d;
            frac_q     <= frac_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_accept) state_d = w_sat ? ST_DONE : ST_ADDR0;
            ST_ADDR0: state_d = ST_ADDR1;
            ST_ADDR1: state_d = ST_CAP1;
            ST_CAP1:  state_d = ST_CALC;
            ST_CALC:  state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values.
    // ------------------------------------------------------------------
    always_comb begin
        ready_d    = 1'b1;
        sign_d     = sign_q;
        func_d     = func_q;
        addr_d     = addr_q;
        frac_d     = frac_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    sign_d = in_data[IN_W-1];
                    func_d = in_func;
                    addr_d = w_addr;
                    frac_d = w_frac;
                    if (w_sat) begin
                        out_data_d = w_sat_val;
                        out_sat_d  = 1'b1;
                    end
                end
            end
            ST_ADDR1: begin
                y0_d = lut_data;
                // Top entry has no successor: interpolate against itself.
                if (w_addr_last) y1_d = lut_data;
            end
            ST_CAP1: begin
                if (!w_addr_last) y1_d = lut_data;
            end
            ST_CALC: begin
                out_data_d = w_interp;
                out_sat_d  = 1'b0;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the current state.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        lut_rd_en = 1'b0;
        lut_addr  = '0;
        case (state_q)
            ST_IDLE:  in_ready = ready_q;
            ST_ADDR0: begin
                lut_rd_en = 1'b1;
                lut_addr  = addr_q;
            end
            ST_ADDR1: begin
                if (!w_addr_last) begin
                    lut_rd_en = 1'b1;
                    lut_addr  = addr_q + ADDR_W'(1);
                end
            end
            ST_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign out_data = out_data_q;
    assign out_sat  = out_sat_q;

endmodule : tanh_sigmoid_unit
`default_nettype wire
